// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types.
// Divider FSM states and packed {rem, quo} result.
package arith_pkg;

  localparam int ARITH_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  typedef struct packed {
    logic [ARITH_DATA_WIDTH-1:0] rem;
    logic [ARITH_DATA_WIDTH-1:0] quo;
  } div_res_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);

  logic [W:0]   part;
  logic [W+1:0] diff;
  logic         unused_hi;

  assign part = {rem, bit_in};
  assign diff = {1'b0, part} - {2'b00, dvs};

  // Borrow out of the W+1 bit subtract means "restore".
  assign q_bit     = ~diff[W+1];
  assign rem_nxt   = q_bit ? diff[W-1:0] : part[W-1:0];
  assign unused_hi = diff[W];

endmodule

// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider, signed/unsigned,
// result packed {remainder, quotient}.
module seq_div
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = ARITH_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  input  logic                    i_signed,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*DATA_WIDTH-1:0] o_c
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  div_state_t state, state_nxt;

  logic [CW-1:0]  cnt;
  logic [W-1:0]   dvd;
  logic [W-1:0]   dvs;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   a_raw;
  logic           neg_q;
  logic           neg_r;
  logic           dbz;
  logic           ovf;
  logic [2*W-1:0] res;

  logic [W-1:0] rem_nxt;
  logic         q_bit;
  logic         a_neg;
  logic         b_neg;
  logic         accept;

  assign a_neg  = i_signed & i_a[W-1];
  assign b_neg  = i_signed & i_b[W-1];
  assign accept = (state == IDLE) && i_valid;

  div_step #(.W(W)) u_step (
    .rem     (rem),
    .bit_in  (dvd[W-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_valid)    state_nxt = CALC;
      CALC: if (cnt[CW-1])  state_nxt = FIX;
      FIX:                  state_nxt = DONE;
      DONE: if (i_ready)    state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  // Counter runs W-1 .. 0 doing steps, then one drain edge at -1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      res   <= '0;
    end else if (accept) begin
      cnt   <= CW'(W-1);
      dvd   <= a_neg ? (~i_a + 1'b1) : i_a;
      dvs   <= b_neg ? (~i_b + 1'b1) : i_b;
      rem   <= '0;
      quo   <= '0;
      a_raw <= i_a;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      dbz   <= (i_b == '0);
      ovf   <= i_signed && (i_a == MIN_NEG) && (i_b == '1);
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      if (!cnt[CW-1]) begin
        rem <= rem_nxt;
        quo <= {quo[W-2:0], q_bit};
        dvd <= {dvd[W-2:0], 1'b0};
      end
    end else if (state == FIX) begin
      unique case (1'b1)
        dbz:     res <= {a_raw, {W{1'b1}}};
        ovf:     res <= {{W{1'b0}}, MIN_NEG};
        default: res <= {neg_r ? (~rem + 1'b1) : rem,
                         neg_q ? (~quo + 1'b1) : quo};
      endcase
    end
  end

  assign o_c = res;

endmodule
